// File: rtl/dac_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dac_serializer
//
// Purpose:
//   Serialises 16-bit stereo samples into an I2S stream for a codec DAC. The
//   codec is bit-clock master: AUD_BCLK and AUD_DACLRCK arrive asynchronously
//   and are synchronised into Clk. All serial activity happens on detected
//   BCLK falling edges ("fall events"). A one-frame holding buffer decouples
//   the producer (valid/ready handshake) from the codec frame timing.
//
// Ports:
//   Clk          system clock, rising edge only
//   Reset        synchronous, active-high reset
//   AUD_BCLK     codec bit clock (asynchronous, <= Clk/8)
//   AUD_DACLRCK  codec word clock (0 = left, 1 = right), asynchronous
//   LDATA/RDATA  left/right sample, two's complement
//   data_valid   LDATA/RDATA hold a frame offered for transfer
//   data_ready   holding buffer is empty (registered)
//   AUD_DACDAT   registered serial data to the codec
//   underrun     one-Clk pulse when a frame starts with the buffer empty
//
// Configuration:
//   DAC_UNDERRUN_HOLD_EN  defined   -> on underrun the previous frame repeats
//                         undefined -> on underrun silence (zeros) is sent
// -----------------------------------------------------------------------------
module dac_serializer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AUD_BCLK,
  input  logic        AUD_DACLRCK,
  input  logic [15:0] LDATA,
  input  logic [15:0] RDATA,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        AUD_DACDAT,
  output logic        underrun
);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LEFT,
    RIGHT
  } state_t;

  localparam logic [4:0] CNT_MAX  = 5'd17;  // saturated: slot padding
  localparam logic [4:0] CNT_DATA = 5'd16;  // last data bit position

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_d;     // previous synchronised BCLK sample
  logic                   lrck_prev;  // LRCK sampled at the previous fall event
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   fall_evt;
  logic                   left_entry;
  logic                   right_entry;

  // Framing and data path
  state_t      state;
  logic [4:0]  bit_cnt;
  logic [4:0]  cnt_inc;
  logic [3:0]  bit_idx;
  logic [15:0] cur_sample;
  logic        ser_bit;
  logic        buf_full;
  logic        buf_full_nxt;
  logic        transfer;
  logic [15:0] buf_l, buf_r;
  logic [15:0] frame_l, frame_r;

  assign bclk_s   = bclk_sync[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync[SYNC_STAGES-1];
  assign fall_evt = bclk_d & ~bclk_s;
  assign transfer = data_valid & data_ready;

  // Channel entries are LRCK edges seen at a fall event. A left entry can only
  // come from WAIT_SYNC or RIGHT, a right entry only from LEFT; an LRCK edge
  // arriving early (short slot) still forces the entry.
  assign left_entry  = fall_evt & ~lrck_s & lrck_prev & (state != LEFT);
  assign right_entry = fall_evt & lrck_s & ~lrck_prev & (state == LEFT);

  // NOTE: every signal written here gets a default first, so no latch can be
  // inferred whatever path the conditions take.
  always_comb begin
    cnt_inc      = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 5'd1;
    cur_sample   = (state == RIGHT) ? frame_r : frame_l;
    // Count n selects sample bit 16-n, so count 1 sends the MSB.
    bit_idx      = 4'(CNT_DATA - cnt_inc);
    ser_bit      = (cnt_inc <= CNT_DATA) ? cur_sample[bit_idx] : 1'b0;
    buf_full_nxt = buf_full;
    if (transfer) begin
      buf_full_nxt = 1'b1;
    end else if (left_entry) begin
      buf_full_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the frame and buffer registers are ordinary flops, not a RAM,
      // so they are cleared with everything else; a reset must not replay
      // stale audio.
      bclk_sync  <= '0;
      lrck_sync  <= '0;
      bclk_d     <= 1'b0;
      lrck_prev  <= 1'b0;
      state      <= WAIT_SYNC;
      bit_cnt    <= '0;
      buf_full   <= 1'b0;
      buf_l      <= '0;
      buf_r      <= '0;
      frame_l    <= '0;
      frame_r    <= '0;
      data_ready <= 1'b0;
      AUD_DACDAT <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_d     <= bclk_s;
      underrun   <= 1'b0;

      // Holding buffer: a transfer needs data_ready, i.e. an empty buffer,
      // so it never collides with the unload at a left entry.
      buf_full   <= buf_full_nxt;
      data_ready <= ~buf_full_nxt;
      if (transfer) begin
        buf_l <= LDATA;
        buf_r <= RDATA;
      end

      if (fall_evt) begin
        lrck_prev <= lrck_s;
        if (left_entry) begin
          state      <= LEFT;
          bit_cnt    <= '0;
          AUD_DACDAT <= 1'b0;  // I2S one-bit delay slot
          if (buf_full) begin
            frame_l <= buf_l;
            frame_r <= buf_r;
          end else begin
            underrun <= 1'b1;
`ifdef DAC_UNDERRUN_HOLD_EN
            // Previous frame stays in place and is sent again.
            frame_l <= frame_l;
            frame_r <= frame_r;
`else
            frame_l <= '0;
            frame_r <= '0;
`endif
          end
        end else if (right_entry) begin
          state      <= RIGHT;
          bit_cnt    <= '0;
          AUD_DACDAT <= 1'b0;
        end else if (state != WAIT_SYNC) begin
          bit_cnt    <= cnt_inc;
          AUD_DACDAT <= ser_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dac_serializer
//
// Drives a behavioural I2S codec (BCLK master, LRCK changing on BCLK falls,
// data captured on BCLK rises) and a producer queue. Expected slot contents
// come from a frame-level model: each frame start consumes the oldest written
// frame, or repeats/silences on underrun; each slot is {0, sample, zeros}
// truncated to the slot length.
// -----------------------------------------------------------------------------
module tb_dac_serializer;

  localparam int HALF_BCLK = 160;  // ns, BCLK = Clk/16

`ifdef DAC_UNDERRUN_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic [15:0] LDATA;
  logic [15:0] RDATA;
  logic        data_valid;
  logic        data_ready;
  logic        AUD_DACDAT;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  frame_t wq[$];             // frames the producer still has to hand over
  frame_t model_pending[$];  // frames written and not yet transmitted
  frame_t model_last;
  int     urun_pulses = 0;
  int     urun_cycles = 0;
  logic   urun_prev   = 1'b0;
  int     xfer_cnt    = 0;
  int     push_cnt    = 0;

  dac_serializer #(.SYNC_STAGES(2)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .LDATA      (LDATA),
    .RDATA      (RDATA),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .AUD_DACDAT (AUD_DACDAT),
    .underrun   (underrun)
  );

  always #10 Clk = ~Clk;

  // Underrun pulse monitor, sampled away from the active edge.
  always @(negedge Clk) begin
    if (underrun === 1'b1) begin
      urun_cycles++;
      if (!urun_prev) urun_pulses++;
    end
    urun_prev = (underrun === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot_word(input logic [15:0] s, input int len);
    logic [31:0] w;
    w = {1'b0, s, 15'b0};
    return w >> (32 - len);
  endfunction

  task automatic push_frame(input frame_t f);
    wq.push_back(f);
    model_pending.push_back(f);
    push_cnt++;
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (wq.size() > 0 && n < 200) begin
      @(posedge Clk);
      n++;
    end
    check(tag, wq.size(), 32'd0);
  endtask

  // Put the codec edges at a fixed phase away from both Clk edges.
  task automatic align();
    @(posedge Clk);
    #7;
  endtask

  task automatic reset_mid_slot();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid dacdat", 32'(AUD_DACDAT), 32'd0);
    check("rst_mid ready", 32'(data_ready), 32'd0);
    check("rst_mid underrun", 32'(underrun), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_mid ready_after", 32'(data_ready), 32'd1);
    align();
  endtask

  // One channel slot of len BCLK periods; LRCK changes on the first fall.
  task automatic codec_slot(input logic lr, input int len, input int rst_pos,
                            output logic [31:0] cap);
    cap = '0;
    for (int p = 0; p < len; p++) begin
      AUD_BCLK = 1'b0;
      if (p == 0) AUD_DACLRCK = lr;
      #(HALF_BCLK);
      AUD_BCLK = 1'b1;
      cap = {cap[30:0], AUD_DACDAT};
      if (p == rst_pos) reset_mid_slot();
      #(HALF_BCLK);
    end
  endtask

  task automatic preamble(input int n, input string tag);
    logic [31:0] cap;
    int ur0 = urun_pulses;
    codec_slot(1'b1, n, -1, cap);
    check({tag, " data"}, cap, 32'd0);
    check({tag, " underrun"}, 32'(urun_pulses - ur0), 32'd0);
  endtask

  task automatic run_frame(input int len, input int rst_pos, input string tag);
    frame_t      cur;
    bit          exp_ur;
    int          ur0;
    logic [31:0] capl, capr, expl, expr;
    ur0 = urun_pulses;
    if (model_pending.size() > 0) begin
      cur    = model_pending.pop_front();
      exp_ur = 1'b0;
    end else begin
      cur    = HOLD_EN ? model_last : '0;
      exp_ur = 1'b1;
    end
    model_last = cur;
    expl = slot_word(cur.l, len);
    if (rst_pos >= 0) expl &= ~((32'd1 << (len - 1 - rst_pos)) - 32'd1);
    codec_slot(1'b0, len, rst_pos, capl);
    check({tag, " left"}, capl, expl);
    if (rst_pos >= 0) begin
      // Reset discards buffered data and drops back to waiting for sync.
      model_pending.delete();
      model_last = '0;
      expr = '0;
    end else begin
      check({tag, " ready"}, 32'(data_ready), 32'(model_pending.size() == 0));
      expr = slot_word(cur.r, len);
    end
    codec_slot(1'b1, len, -1, capr);
    check({tag, " right"}, capr, expr);
    check({tag, " underrun"}, 32'(urun_pulses - ur0), 32'(exp_ur));
  endtask

  initial begin
    logic [15:0] base_l, base_r;
    frame_t      f;
    Reset       = 1'b1;
    AUD_BCLK    = 1'b1;
    AUD_DACLRCK = 1'b1;
    data_valid  = 1'b0;
    LDATA       = '0;
    RDATA       = '0;
    model_last  = '0;

    // Producer: offers the head of wq, pops it when the handshake completes.
    fork
      forever begin
        bit accept;
        @(negedge Clk);
        if (wq.size() > 0) begin
          data_valid = 1'b1;
          LDATA      = wq[0].l;
          RDATA      = wq[0].r;
        end else begin
          data_valid = 1'b0;
        end
        #2;
        accept = !Reset && data_valid && (data_ready === 1'b1);
        @(posedge Clk);
        if (accept) begin
          void'(wq.pop_front());
          xfer_cnt++;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset dacdat", 32'(AUD_DACDAT), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    check("reset ready", 32'(data_ready), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_reset ready", 32'(data_ready), 32'd1);

    // Single frame written before the first LRCK fall
    push_frame('{l: 16'hA5C3, r: 16'h0F0F});
    wait_drained("t1 drain");
    @(negedge Clk);
    check("t1 ready_low", 32'(data_ready), 32'd0);
    align();
    preamble(6, "t1 wait_sync");
    run_frame(32, -1, "t1");

    // Continuous valid: eight incrementing frames, one transfer per frame
    base_l = 16'($urandom);
    base_r = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      f.l = base_l + 16'(k);
      f.r = base_r + 16'(k);
      push_frame(f);
    end
    repeat (10) @(posedge Clk);
    check("t2 one_xfer", wq.size(), 32'd7);
    @(negedge Clk);
    check("t2 ready_low", 32'(data_ready), 32'd0);
    align();
    for (int k = 0; k < 8; k++) run_frame(32, -1, $sformatf("t2 f%0d", k));
    check("t2 drained", wq.size(), 32'd0);

    // Underrun after a single frame
    push_frame('{l: 16'h8001, r: 16'h7FFE});
    wait_drained("t3 drain");
    align();
    for (int k = 0; k < 3; k++) run_frame(32, -1, $sformatf("t3 f%0d", k));

    // Reset during bit 7 of the left slot, with a second frame buffered
    f.l = 16'($urandom) | 16'h03FF;
    f.r = 16'($urandom);
    push_frame(f);
    f.l = 16'($urandom);
    f.r = 16'($urandom);
    push_frame(f);
    repeat (10) @(posedge Clk);
    check("t4 one_xfer", wq.size(), 32'd1);
    align();
    run_frame(32, 7, "t4 rst");
    check("t4 second_taken", wq.size(), 32'd0);
    f.l = 16'($urandom);
    f.r = 16'($urandom);
    push_frame(f);
    wait_drained("t4 drain");
    align();
    run_frame(32, -1, "t4 after");

    // 32-bit slots followed by 12-bit slots
    f.l = 16'($urandom);
    f.r = 16'($urandom);
    push_frame(f);
    wait_drained("t5 drain");
    align();
    run_frame(32, -1, "t5 long");
    for (int k = 0; k < 2; k++) begin
      f.l = 16'($urandom);
      f.r = 16'($urandom);
      push_frame(f);
    end
    repeat (10) @(posedge Clk);
    align();
    run_frame(12, -1, "t5 short0");
    run_frame(12, -1, "t5 short1");

    check("underrun width", 32'(urun_cycles), 32'(urun_pulses));
    check("transfer count", 32'(xfer_cnt), 32'(push_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
